// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// ACK of address/data bytes, received bytes buffered in a FIFO. Optional macro: I2C_RX_GLITCH_FILTER_EN.
module i2c_target_rx #(
  parameter logic [6:0] ADDR       = 7'h42,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       selected,
  output logic       busy,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_l, sda_l;
  logic scl_prev_q, sda_prev_q;
  logic start_ev, stop_ev, rise_ev, fall_ev;

  logic [3:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        ack_q;
  logic        overrun_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, push_ok, pop;
  logic [7:0]  byte_in;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_RX_GLITCH_FILTER_EN
  // Line follows the synchronizer only once three consecutive samples agree.
  logic scl_h1_q, scl_h2_q, scl_f_q, sda_h1_q, sda_h2_q, sda_f_q;

  always_comb begin
    scl_l = ((scl_s2_q == scl_h1_q) && (scl_h1_q == scl_h2_q)) ? scl_s2_q : scl_f_q;
    sda_l = ((sda_s2_q == sda_h1_q) && (sda_h1_q == sda_h2_q)) ? sda_s2_q : sda_f_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_h1_q <= 1'b1;
      scl_h2_q <= 1'b1;
      scl_f_q  <= 1'b1;
      sda_h1_q <= 1'b1;
      sda_h2_q <= 1'b1;
      sda_f_q  <= 1'b1;
    end else begin
      scl_h1_q <= scl_s2_q;
      scl_h2_q <= scl_h1_q;
      scl_f_q  <= scl_l;
      sda_h1_q <= sda_s2_q;
      sda_h2_q <= sda_h1_q;
      sda_f_q  <= sda_l;
    end
  end
`else
  assign scl_l = scl_s2_q;
  assign sda_l = sda_s2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_l;
      sda_prev_q <= sda_l;
    end
  end

  assign start_ev = scl_l & scl_prev_q & sda_prev_q & ~sda_l;
  assign stop_ev  = scl_l & scl_prev_q & ~sda_prev_q & sda_l;
  assign rise_ev  = scl_l & ~scl_prev_q;
  assign fall_ev  = ~scl_l & scl_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_ev)     state_d = S_ADDR;
    else if (stop_ev) state_d = S_IDLE;
    else begin
      case (state_q)
        S_ADDR:
          if (fall_ev && bit_cnt_q == 4'd8)
            state_d = (shreg_q[7:1] == ADDR && !shreg_q[0]) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (fall_ev) state_d = S_DATA;
        S_DATA:     if (fall_ev && bit_cnt_q == 4'd8) state_d = S_DATA_ACK;
        S_DATA_ACK: if (fall_ev) state_d = S_DATA;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_oe   = (state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK && ack_q);
    selected = (state_q == S_DATA) || (state_q == S_DATA_ACK);
    busy     = (state_q != S_IDLE);
  end

  assign byte_in = {shreg_q[6:0], sda_l};
  assign push    = (state_q == S_DATA) && rise_ev && (bit_cnt_q == 4'd7);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Full is judged before any same-cycle pop, so a full FIFO always NAKs.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop     = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt_q <= 4'd0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (start_ev || stop_ev) begin
        bit_cnt_q <= 4'd0;
      end else if (rise_ev && (state_q == S_ADDR || state_q == S_DATA) && bit_cnt_q < 4'd8) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end else if (fall_ev && (state_q == S_ADDR_ACK || state_q == S_DATA_ACK)) begin
        bit_cnt_q <= 4'd0;
      end
      if (push) begin
        ack_q <= !full;
        if (full) overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rise_ev && (state_q == S_ADDR || state_q == S_DATA) && bit_cnt_q < 4'd8)
      shreg_q <= byte_in;
    if (push_ok)
      mem_q[wr_ptr_q[AW-1:0]] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rx_valid = !empty;
  assign rx_data  = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign overrun  = overrun_q;

endmodule
